uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART receiver. It generates the `sample_en` bit-centre tick from a runtime baud divisor, aligned to each frame start reported through `rx_busy`. It captures every received byte with its error flags into a first-word-fall-through FIFO with a valid/ready output. It also flags inter-message idle gaps and keeps overflow and false-start statistics.

## Interface
Parameters:
- `DIV_W`, 16, width of the clocks-per-bit divisor.
- `FIFO_AW`, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cfg_div`  in  DIV_W  clocks per bit; legal range ≥ 8
- `cfg_idle`  in  8  idle bit-times that end a message; 0 disables
- `rx_busy`  in  1  receiver busy level
- `rx_data`  in  8  received byte
- `rx_new_data`  in  1  one-cycle byte-valid pulse
- `parity_error`  in  1  valid in the `rx_new_data` cycle
- `end_error`  in  1  stop-bit error; pulses with `rx_new_data`
- `begin_error`  in  1  false-start pulse
- `sample_en`  out  1  one-cycle bit-sample tick to the receiver
- `m_data`  out  8  head byte
- `m_err`  out  2  head flags, [0] parity, [1] framing
- `m_valid`  out  1  FIFO not empty
- `m_ready`  in  1  consumer accept
- `fifo_level`  out  FIFO_AW+1  entries held
- `overflow`  out  1  sticky; a byte was dropped
- `ovf_clr`  in  1  clears `overflow`
- `glitch_cnt`  out  8  saturating count of `begin_error` pulses
- `msg_idle`  out  1  one-cycle pulse at the end of an idle gap

## Operation
- Tick generator states: IDLE, FIRST, RUN.
  - IDLE → FIRST when `rx_busy` is 0 in the previous cycle and 1 now.
  - On that transition, latch `cfg_div` into `div_q` and load `cnt = (cfg_div>>1) + 3`.
  - FIRST/RUN decrement `cnt` each cycle. At `cnt == 0`, pulse `sample_en`, reload `div_q-1`, and go to RUN.
  - Any cycle with `rx_busy` = 0 forces IDLE, `cnt` = 0, and no tick.
- Capture path:
  - On `rx_new_data`, push {`end_error`, `parity_error`, `rx_data`}.
  - Push succeeds if `fifo_level < depth` or a pop occurs in the same cycle. Otherwise the byte is dropped and `overflow` is set.
  - `ovf_clr` clears `overflow`; a set in the same cycle wins.
- Pop: `m_valid & m_ready` removes the head entry. `m_data` and `m_err` must hold stable while `m_valid & !m_ready`.
- `begin_error` increments `glitch_cnt`, saturating at 255. It produces no FIFO entry.
- Idle detector:
  - Armed by any successful push.
  - While armed and `rx_busy` = 0, count bit-times of `cfg_div` cycles each.
  - When the count reaches `cfg_idle`, pulse `msg_idle` and disarm.
  - `rx_busy` = 1 clears the count but keeps the detector armed.
  - `cfg_idle` = 0 keeps the detector disarmed.
- Reset values: `sample_en` 0, `m_valid` 0, `fifo_level` 0, `overflow` 0, `glitch_cnt` 0, `msg_idle` 0, `m_data`/`m_err` 0. State is IDLE and the detector is disarmed.
- Reset mid-frame discards the FIFO contents and any partially timed bit.

## Timing
- The first cycle `rx_busy` reads 1 is cycle 0. The first `sample_en` is at cycle `(cfg_div>>1)+4`, then every `div_q` cycles while busy. The +4 accounts for the receiver's synchroniser delay relative to `rx_busy`.
- `cfg_div` changes mid-frame take effect from the next frame.
- A push at cycle t gives `m_valid` = 1 and the new `fifo_level` at t+1.
- A pop at cycle t updates the head at t+1.
- A simultaneous push and pop leaves `fifo_level` unchanged.
- `msg_idle` is registered, one cycle after the terminating bit-time count.

## Structure
- Shared package `uart_pkg`: `UART_ERR_PAR = 0`, `UART_ERR_FRM = 1`, `UART_RX_SYNC_LAT = 4`, `UART_MIN_DIV = 8`, and the 10-bit entry layout.
- One sub-module, `uart_sync_fifo` (10-bit wide, FWFT, count output). This is reusable by the transmit side.
- Tick generator, idle detector and counters stay in `uart_rx_ctrl`.

## Test plan
- `cfg_div` = 16; byte 0xA5 at 8N1 driven through the receiver → `sample_en` at cycles 12, 28, …; `m_data` = 0xA5, `m_err` = 0, `m_valid` one cycle after `rx_new_data`.
- Parity enabled, wrong parity bit on 0x3C → entry 0x3C with `m_err` = 2'b01. Stop bit low → `m_err[1]` = 1.
- Hold `m_ready` = 0 and send 17 bytes with `FIFO_AW` = 4 → `fifo_level` = 16, 17th byte dropped, `overflow` = 1. Then `ovf_clr` → 0. Then drain in order.
- Full FIFO with push and pop in the same cycle → level stays 16, no overflow, new byte at tail.
- Two 1-bit-time low glitches → `glitch_cnt` = 2, no FIFO entry, no stray `sample_en` after `rx_busy` drops.
- `cfg_idle` = 3, one byte, then line idle → single `msg_idle` pulse at 3×`cfg_div` cycles after `rx_busy` falls. Assert `reset` mid-frame → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and entry layout shared by the UART receive and transmit controllers.
package uart_pkg;

   localparam int UART_ERR_PAR     = 0;
   localparam int UART_ERR_FRM     = 1;
   localparam int UART_RX_SYNC_LAT = 4;
   localparam int UART_MIN_DIV     = 8;
   localparam int UART_ENTRY_W     = 10;

   typedef struct packed {
      logic [1:0] err;
      logic [7:0] data;
   } uart_entry_t;

   function automatic uart_entry_t uart_pack_entry(input logic [7:0] data,
                                                   input logic       par_err,
                                                   input logic       frm_err);
      uart_entry_t e;
      e.data              = data;
      e.err               = 2'b00;
      e.err[UART_ERR_PAR] = par_err;
      e.err[UART_ERR_FRM] = frm_err;
      return e;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W  = UART_ENTRY_W,
   parameter int AW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic          valid_o,
   output logic [AW:0]   count_o,
   output logic          push_ok_o
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          pop_ok_s, push_ok_s;

   assign pop_ok_s  = pop_i & (count_q != {(AW+1){1'b0}});
   assign push_ok_s = push_i & ((count_q != (AW+1)'(DEPTH)) | pop_ok_s);

   // Storage array; contents are don't-care until written, so it carries no reset.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign valid_o   = (count_q != {(AW+1){1'b0}});
   assign data_o    = valid_o ? mem_q[rd_ptr_q] : {W{1'b0}};
   assign count_o   = count_q;
   assign push_ok_o = push_ok_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: bit-centre tick generation, received-byte FIFO,
// overflow / false-start statistics and inter-message idle detection.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int FIFO_AW = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic [7:0]         cfg_idle,
   input  logic               rx_busy,
   input  logic [7:0]         rx_data,
   input  logic               rx_new_data,
   input  logic               parity_error,
   input  logic               end_error,
   input  logic               begin_error,
   output logic               sample_en,
   output logic [7:0]         m_data,
   output logic [1:0]         m_err,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   input  logic               ovf_clr,
   output logic [7:0]         glitch_cnt,
   output logic               msg_idle
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             busy_q;
   logic             tick_s;

   // First tick lands half a bit plus the receiver's synchroniser delay after busy rises.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      tick_s  = 1'b0;
      if (!rx_busy) begin
         state_d = ST_IDLE;
         cnt_d   = {DIV_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!busy_q) begin
                  state_d = ST_FIRST;
                  div_d   = cfg_div;
                  cnt_d   = (cfg_div >> 1) + DIV_W'(UART_RX_SYNC_LAT - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FIRST, ST_RUN: begin
               if (cnt_q == {DIV_W{1'b0}}) begin
                  tick_s  = 1'b1;
                  cnt_d   = div_q - DIV_W'(1);
                  state_d = ST_RUN;
               end else begin
                  cnt_d   = cnt_q - DIV_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {DIV_W{1'b0}};
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {DIV_W{1'b0}};
         div_q   <= {DIV_W{1'b0}};
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         busy_q  <= rx_busy;
      end
   end

   assign sample_en = tick_s;

   uart_entry_t push_entry_s, head_s;
   logic        push_ok_s;

   assign push_entry_s = uart_pack_entry(rx_data, parity_error, end_error);

   uart_sync_fifo #(
      .W  (UART_ENTRY_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_i    (rx_new_data),
      .data_i    (push_entry_s),
      .pop_i     (m_ready),
      .data_o    (head_s),
      .valid_o   (m_valid),
      .count_o   (fifo_level),
      .push_ok_o (push_ok_s)
   );

   assign m_data = head_s.data;
   assign m_err  = head_s.err;

   logic       overflow_q;
   logic [7:0] glitch_q;

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q <= 1'b0;
         glitch_q   <= 8'd0;
      end else begin
         if (rx_new_data && !push_ok_s) overflow_q <= 1'b1;
         else if (ovf_clr)              overflow_q <= 1'b0;
         if (begin_error && (glitch_q != 8'hFF)) glitch_q <= glitch_q + 8'd1;
      end
   end

   assign overflow   = overflow_q;
   assign glitch_cnt = glitch_q;

   logic             armed_q, armed_d;
   logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       idle_cnt_q, idle_cnt_d;
   logic             msg_idle_q, msg_idle_d;

   always_comb begin
      armed_d    = armed_q;
      bit_cnt_d  = bit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      msg_idle_d = 1'b0;
      if (cfg_idle == 8'd0) begin
         armed_d    = 1'b0;
         bit_cnt_d  = {DIV_W{1'b0}};
         idle_cnt_d = 8'd0;
      end else if (push_ok_s) begin
         armed_d    = 1'b1;
         bit_cnt_d  = {DIV_W{1'b0}};
         idle_cnt_d = 8'd0;
      end else if (!armed_q || rx_busy) begin
         bit_cnt_d  = {DIV_W{1'b0}};
         idle_cnt_d = 8'd0;
      end else if (bit_cnt_q == cfg_div - DIV_W'(1)) begin
         bit_cnt_d = {DIV_W{1'b0}};
         if (idle_cnt_q == cfg_idle - 8'd1) begin
            msg_idle_d = 1'b1;
            armed_d    = 1'b0;
            idle_cnt_d = 8'd0;
         end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
         end
      end else begin
         bit_cnt_d = bit_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         armed_q    <= 1'b0;
         bit_cnt_q  <= {DIV_W{1'b0}};
         idle_cnt_q <= 8'd0;
         msg_idle_q <= 1'b0;
      end else begin
         armed_q    <= armed_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         msg_idle_q <= msg_idle_d;
      end
   end

   assign msg_idle = msg_idle_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl, scored every cycle against a frame-timing,
// queue-based and gap-length reference model.
module tb_uart_rx_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cfg_div;
   logic [7:0]  cfg_idle;
   logic        rx_busy, rx_new_data, parity_error, end_error, begin_error;
   logic [7:0]  rx_data;
   logic        sample_en, m_valid, m_ready, overflow, ovf_clr, msg_idle;
   logic [7:0]  m_data, glitch_cnt;
   logic [1:0]  m_err;
   logic [4:0]  fifo_level;

   always #5 clock = ~clock;

   uart_rx_ctrl #(.DIV_W(16), .FIFO_AW(4)) dut (
      .clock(clock), .reset(reset), .cfg_div(cfg_div), .cfg_idle(cfg_idle),
      .rx_busy(rx_busy), .rx_data(rx_data), .rx_new_data(rx_new_data),
      .parity_error(parity_error), .end_error(end_error), .begin_error(begin_error),
      .sample_en(sample_en), .m_data(m_data), .m_err(m_err), .m_valid(m_valid),
      .m_ready(m_ready), .fifo_level(fifo_level), .overflow(overflow),
      .ovf_clr(ovf_clr), .glitch_cnt(glitch_cnt), .msg_idle(msg_idle)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
   endtask

   // Reference model state
   bit         m_prev, m_run;
   int         m_age, m_div = 16;
   logic [9:0] m_q[$];
   bit         m_ovf, m_armed, m_idle_pend;
   int         m_glitch, m_gap;
   bit         rand_ready = 1'b0;

   task automatic model_clear();
      m_prev = 1'b0; m_run = 1'b0; m_age = 0;
      m_q.delete();
      m_ovf = 1'b0; m_glitch = 0; m_armed = 1'b0; m_gap = 0; m_idle_pend = 1'b0;
   endtask

   // One clock: randomise handshake inputs, check outputs at negedge, advance model at posedge.
   task automatic cycle();
      bit         act, exp_tick, pushed;
      int         age, dv, first;
      logic [9:0] head;
      if (rand_ready) begin
         m_ready = ($urandom_range(0, 2) != 0);
         ovf_clr = ($urandom_range(0, 15) == 0);
      end
      @(negedge clock);
      if (rx_busy && !m_prev) begin
         act = 1'b1; age = 0; dv = int'(cfg_div);
      end else if (rx_busy && m_run) begin
         act = 1'b1; age = m_age; dv = m_div;
      end else begin
         act = 1'b0; age = 0; dv = m_div;
      end
      first    = dv / 2 + 4;
      exp_tick = act && (age >= first) && (((age - first) % dv) == 0);
      head     = (m_q.size() > 0) ? m_q[0] : 10'd0;
      if (!reset) begin
         check_eq("sample_en",  sample_en,  exp_tick);
         check_eq("m_valid",    m_valid,    m_q.size() > 0);
         check_eq("m_data",     m_data,     head[7:0]);
         check_eq("m_err",      m_err,      head[9:8]);
         check_eq("fifo_level", fifo_level, m_q.size());
         check_eq("overflow",   overflow,   m_ovf);
         check_eq("glitch_cnt", glitch_cnt, m_glitch);
         check_eq("msg_idle",   msg_idle,   m_idle_pend);
      end
      @(posedge clock);
      if (reset) begin
         model_clear();
      end else begin
         m_prev = rx_busy; m_run = act; m_age = age + 1; m_div = dv;
         if (m_q.size() > 0 && m_ready) void'(m_q.pop_front());
         pushed = 1'b0;
         if (rx_new_data && m_q.size() < 16) begin
            m_q.push_back({end_error, parity_error, rx_data});
            pushed = 1'b1;
         end
         if (rx_new_data && !pushed) m_ovf = 1'b1;
         else if (ovf_clr)           m_ovf = 1'b0;
         if (begin_error && m_glitch < 255) m_glitch++;
         m_idle_pend = 1'b0;
         if (cfg_idle == 8'd0) begin
            m_armed = 1'b0; m_gap = 0;
         end else if (pushed) begin
            m_armed = 1'b1; m_gap = 0;
         end else if (!m_armed || rx_busy) begin
            m_gap = 0;
         end else begin
            m_gap++;
            if (m_gap == int'(cfg_idle) * int'(cfg_div)) begin
               m_idle_pend = 1'b1; m_armed = 1'b0; m_gap = 0;
            end
         end
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit perr, input bit ferr,
                             input int gap, input int new_div);
      int d;
      d = int'(cfg_div);
      rx_busy = 1'b1;
      repeat (d * 4) cycle();
      if (new_div != 0) cfg_div = 16'(new_div);
      repeat (d * 5 + d / 2) cycle();
      rx_data = b; parity_error = perr; end_error = ferr; rx_new_data = 1'b1;
      cycle();
      rx_new_data = 1'b0; parity_error = 1'b0; end_error = 1'b0;
      repeat (3) cycle();
      rx_busy = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic send_glitch();
      rx_busy = 1'b1;
      repeat (int'(cfg_div) / 2 + 4) cycle();
      begin_error = 1'b1;
      cycle();
      begin_error = 1'b0; rx_busy = 1'b0;
      repeat (int'(cfg_div)) cycle();
   endtask

   task automatic push_raw(input logic [7:0] b);
      rx_data = b; rx_new_data = 1'b1;
      cycle();
      rx_new_data = 1'b0;
      cycle();
   endtask

   initial begin
      reset = 1'b1; cfg_div = 16'd16; cfg_idle = 8'd0; rx_busy = 1'b0;
      rx_data = 8'd0; rx_new_data = 1'b0; parity_error = 1'b0; end_error = 1'b0;
      begin_error = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
      model_clear();
      repeat (2) cycle();
      reset = 1'b0;
      repeat (2) cycle();

      // Clean byte, parity error, framing error, divisor change mid-frame
      m_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0, 20, 0);
      send_frame(8'h3C, 1'b1, 1'b0, 20, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 20, 10);
      cfg_div = 16'd16;

      // Overflow with consumer stalled, clear, full push+pop, drain
      m_ready = 1'b0;
      for (int i = 0; i < 17; i++) push_raw(8'(i + 8'h40));
      ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0; cycle();
      m_ready = 1'b1; rx_data = 8'hEE; rx_new_data = 1'b1; cycle();
      rx_new_data = 1'b0; m_ready = 1'b0; repeat (2) cycle();
      m_ready = 1'b1;
      repeat (20) cycle();

      // False starts
      send_glitch();
      send_glitch();

      // Idle gap detection
      cfg_idle = 8'd3;
      send_frame(8'h81, 1'b0, 1'b0, 60, 0);

      // Randomized traffic
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (!m_armed) begin
            cfg_div  = 16'($urandom_range(8, 24));
            cfg_idle = 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 4) == 0) send_glitch();
         else send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         $urandom_range(0, 80), 0);
      end
      rand_ready = 1'b0; ovf_clr = 1'b0;

      // Reset mid-frame with data held in the FIFO
      m_ready = 1'b0; cfg_div = 16'd16;
      push_raw(8'h77);
      rx_busy = 1'b1;
      repeat (30) cycle();
      reset = 1'b1; rx_busy = 1'b0;
      cycle();
      reset = 1'b0;
      repeat (3) cycle();
      m_ready = 1'b1;
      send_frame(8'h12, 1'b0, 1'b0, 10, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
